fifo_serializer: RTL and testbench

- Drains entries from a show-ahead FIFO (push/pop/empty/full/wdata/rdata style) and emits each entry as a sequence of narrow beats on a val/rdy output stream.
- Sits directly downstream of the FIFO.
- Pops exactly one entry per serialized message.
- Sustains full throughput: one beat per cycle, no bubble between consecutive entries.

---
 rtl/fifo_serializer_if.sv | 23 ++
 rtl/fifo_serializer.sv | 85 ++++++++
 tb/tb_fifo_serializer.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_serializer_if.sv
// Handshake bundle between the serializer, its upstream show-ahead FIFO and the downstream beat consumer.
interface fifo_serializer_if #(
    parameter int unsigned p_entry_bits = 32,
    parameter int unsigned p_beat_bits  = 8
);
    logic                    fifo_empty;
    logic [p_entry_bits-1:0] fifo_rdata;
    logic                    fifo_pop;
    logic                    out_val;
    logic                    out_rdy;
    logic [p_beat_bits-1:0]  out_msg;
    logic                    out_last;

    modport master (
        input  fifo_empty, fifo_rdata, out_rdy,
        output fifo_pop, out_val, out_msg, out_last
    );

    modport slave (
        output fifo_empty, fifo_rdata, out_rdy,
        input  fifo_pop, out_val, out_msg, out_last
    );
endinterface

// File: rtl/fifo_serializer.sv
// Pops one entry per message from a show-ahead FIFO and streams it LSB-first as narrow val/rdy beats,
// reloading directly from the FIFO on the last beat so consecutive entries leave without a bubble.
module fifo_serializer #(
    parameter int unsigned p_entry_bits = 32,
    parameter int unsigned p_beat_bits  = 8
) (
    input  logic               clk,
    input  logic               rst,
    fifo_serializer_if.master  bus
);
    localparam int unsigned p_num_beats = p_entry_bits / p_beat_bits;
    localparam int unsigned lp_cnt_bits = (p_num_beats > 1) ? $clog2(p_num_beats) : 1;
    localparam logic [lp_cnt_bits-1:0] lp_last_cnt = lp_cnt_bits'(p_num_beats - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [p_entry_bits-1:0] r_shift;
    logic [p_entry_bits-1:0] w_shift_nxt;
    logic [lp_cnt_bits-1:0]  r_cnt;
    logic [lp_cnt_bits-1:0]  w_cnt_nxt;
    logic                    w_last;
    logic                    w_pop;

    assign w_last = (r_cnt == lp_last_cnt);

    // State, shift register and beat counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and pop decode; a reload on the last beat keeps the stream gap-free
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!bus.fifo_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = bus.fifo_rdata;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (bus.out_rdy) begin
                    if (!w_last) begin
                        w_shift_nxt = r_shift >> p_beat_bits;
                        w_cnt_nxt   = r_cnt + lp_cnt_bits'(1);
                    end else if (!bus.fifo_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = bus.fifo_rdata;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Pop is held off while in reset so nothing is lost from the FIFO during reset
    assign bus.fifo_pop = w_pop & rst;
    assign bus.out_val  = (r_state == ST_SEND);
    assign bus.out_msg  = r_shift[p_beat_bits-1:0];
    assign bus.out_last = (r_state == ST_SEND) & w_last;

endmodule

// File: tb/tb_fifo_serializer.sv
// Bench for fifo_serializer: directed vector table and corner sequences on 32/8, then randomized
// traffic on 32/8, 16/16 and 24/8 checked against a queue-of-beats reference model.
module tb_fifo_serializer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  sel;
    logic        tb_empty;
    logic        tb_rdy;
    logic [31:0] tb_rdata;

    logic        dut_pop;
    logic        dut_val;
    logic [15:0] dut_msg;
    logic        dut_last;

    fifo_serializer_if #(.p_entry_bits(32), .p_beat_bits(8))  bus0 ();
    fifo_serializer_if #(.p_entry_bits(16), .p_beat_bits(16)) bus1 ();
    fifo_serializer_if #(.p_entry_bits(24), .p_beat_bits(8))  bus2 ();

    fifo_serializer #(.p_entry_bits(32), .p_beat_bits(8))  dut0 (.clk(clk), .rst(rst), .bus(bus0));
    fifo_serializer #(.p_entry_bits(16), .p_beat_bits(16)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    fifo_serializer #(.p_entry_bits(24), .p_beat_bits(8))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

    // Only the selected instance sees a non-empty FIFO
    assign bus0.fifo_empty = (sel == 2'd0) ? tb_empty : 1'b1;
    assign bus1.fifo_empty = (sel == 2'd1) ? tb_empty : 1'b1;
    assign bus2.fifo_empty = (sel == 2'd2) ? tb_empty : 1'b1;
    assign bus0.fifo_rdata = tb_rdata;
    assign bus1.fifo_rdata = tb_rdata[15:0];
    assign bus2.fifo_rdata = tb_rdata[23:0];
    assign bus0.out_rdy    = tb_rdy;
    assign bus1.out_rdy    = tb_rdy;
    assign bus2.out_rdy    = tb_rdy;

    always_comb begin
        dut_pop  = bus0.fifo_pop;
        dut_val  = bus0.out_val;
        dut_msg  = 16'(bus0.out_msg);
        dut_last = bus0.out_last;
        case (sel)
            2'd1: begin
                dut_pop  = bus1.fifo_pop;
                dut_val  = bus1.out_val;
                dut_msg  = bus1.out_msg;
                dut_last = bus1.out_last;
            end
            2'd2: begin
                dut_pop  = bus2.fifo_pop;
                dut_val  = bus2.out_val;
                dut_msg  = 16'(bus2.out_msg);
                dut_last = bus2.out_last;
            end
            default: begin
            end
        endcase
    end

    typedef struct {
        logic        push;
        logic [31:0] wd;
        logic        rdy;
        logic        e_pop;
        logic        e_val;
        logic [7:0]  e_msg;
        logic        e_last;
    } vec_t;

    typedef struct {
        logic [15:0] msg;
        logic        last;
    } beat_t;

    logic [31:0] fq[$];
    beat_t       exp_q[$];

    int          n_vec = 0;
    int          n_err = 0;

    logic        s_pop, s_val, s_last, s_empty;
    logic [15:0] s_msg;
    logic [31:0] s_head;
    logic        prev_stall;
    logic [15:0] prev_msg;
    logic        prev_last;

    int e_bits[3];
    int b_bits[3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic upd();
        tb_empty = (fq.size() == 0);
        tb_rdata = (fq.size() != 0) ? fq[0] : 32'h0;
    endtask

    // Sample mid-cycle, then let the clock edge act; the FIFO model honours a sampled pop just after the edge
    task automatic tick();
        @(negedge clk);
        s_pop   = dut_pop;
        s_val   = dut_val;
        s_msg   = dut_msg;
        s_last  = dut_last;
        s_empty = tb_empty;
        s_head  = tb_rdata;
        @(posedge clk);
        #1;
        if (s_pop && fq.size() != 0) void'(fq.pop_front());
        upd();
    endtask

    // Reference: pending beats of already-popped entries decide val, pop, and the beat content
    task automatic model(input int c);
        int    nb;
        int    bb;
        logic [31:0] bmask;
        logic  e_pop;
        bb    = b_bits[c];
        nb    = e_bits[c] / bb;
        bmask = (bb >= 32) ? 32'hffff_ffff : ((32'd1 << bb) - 32'd1);
        chk("rand.val", 32'(s_val), 32'(exp_q.size() != 0));
        e_pop = !s_empty && (exp_q.size() == 0 || (exp_q.size() == 1 && tb_rdy));
        chk("rand.pop", 32'(s_pop), 32'(e_pop));
        if (s_val && prev_stall) begin
            chk("rand.hold_msg", 32'(s_msg), 32'(prev_msg));
            chk("rand.hold_last", 32'(s_last), 32'(prev_last));
        end
        if (s_val && tb_rdy && exp_q.size() != 0) begin
            chk("rand.msg", 32'(s_msg), 32'(exp_q[0].msg));
            chk("rand.last", 32'(s_last), 32'(exp_q[0].last));
            void'(exp_q.pop_front());
        end
        if (s_pop && !s_empty) begin
            for (int b = 0; b < nb; b++) begin
                beat_t x;
                x.msg  = 16'((s_head >> (b * bb)) & bmask);
                x.last = (b == nb - 1);
                exp_q.push_back(x);
            end
        end
        prev_stall = s_val && !tb_rdy;
        prev_msg   = s_msg;
        prev_last  = s_last;
    endtask

    function automatic vec_t mk(input logic push, input logic [31:0] wd, input logic rdy,
                                input logic e_pop, input logic e_val, input logic [7:0] e_msg,
                                input logic e_last);
        vec_t v;
        v.push = push; v.wd = wd; v.rdy = rdy;
        v.e_pop = e_pop; v.e_val = e_val; v.e_msg = e_msg; v.e_last = e_last;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[25];
        logic [7:0] eb[4];
        int         cnt;
        logic [31:0] mask;

        e_bits[0] = 32; e_bits[1] = 16; e_bits[2] = 24;
        b_bits[0] = 8;  b_bits[1] = 16; b_bits[2] = 8;

        // Basic single entry
        tbl[0]  = mk(1'b1, 32'hdeadbeef, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        tbl[1]  = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'hef, 1'b0);
        tbl[2]  = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'hbe, 1'b0);
        tbl[3]  = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'had, 1'b0);
        tbl[4]  = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'hde, 1'b1);
        tbl[5]  = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        // Back-to-back entries, second pop on beat 0x03
        tbl[6]  = mk(1'b1, 32'h03020100, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        tbl[7]  = mk(1'b1, 32'h07060504, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        tbl[8]  = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h01, 1'b0);
        tbl[9]  = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h02, 1'b0);
        tbl[10] = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 8'h03, 1'b1);
        tbl[11] = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h04, 1'b0);
        tbl[12] = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h05, 1'b0);
        tbl[13] = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h06, 1'b0);
        tbl[14] = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h07, 1'b1);
        tbl[15] = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        // Backpressure for three cycles on beat 0xbe
        tbl[16] = mk(1'b1, 32'hdeadbeef, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        tbl[17] = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'hef, 1'b0);
        tbl[18] = mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'hbe, 1'b0);
        tbl[19] = mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'hbe, 1'b0);
        tbl[20] = mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'hbe, 1'b0);
        tbl[21] = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'hbe, 1'b0);
        tbl[22] = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'had, 1'b0);
        tbl[23] = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'hde, 1'b1);
        tbl[24] = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

        sel = 2'd0;
        tb_rdy = 1'b0;
        prev_stall = 1'b0;
        prev_msg = '0;
        prev_last = 1'b0;
        upd();

        // Reset state
        #2;
        chk("reset.pop", 32'(dut_pop), 32'd0);
        chk("reset.val", 32'(dut_val), 32'd0);
        chk("reset.last", 32'(dut_last), 32'd0);
        chk("reset.msg", 32'(dut_msg), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 25; i++) begin
            if (tbl[i].push) begin
                fq.push_back(tbl[i].wd);
                upd();
            end
            tb_rdy = tbl[i].rdy;
            tick();
            chk($sformatf("tbl%0d.pop", i), 32'(s_pop), 32'(tbl[i].e_pop));
            chk($sformatf("tbl%0d.val", i), 32'(s_val), 32'(tbl[i].e_val));
            if (tbl[i].e_val) begin
                chk($sformatf("tbl%0d.msg", i), 32'(s_msg), 32'(tbl[i].e_msg));
                chk($sformatf("tbl%0d.last", i), 32'(s_last), 32'(tbl[i].e_last));
            end
        end

        // Idle with an empty FIFO
        for (int i = 0; i < 10; i++) begin
            tb_rdy = i[0];
            tick();
            chk("idle.pop", 32'(s_pop), 32'd0);
            chk("idle.val", 32'(s_val), 32'd0);
        end

        // Asynchronous reset in the middle of an entry
        tb_rdy = 1'b1;
        fq.push_back(32'hdeadbeef);
        upd();
        tick();
        chk("rstmid.pop", 32'(s_pop), 32'd1);
        tick();
        chk("rstmid.ef", 32'(s_msg), 32'hef);
        #2;
        chk("rstmid.be_before", 32'(dut_msg), 32'hbe);
        rst = 1'b0;
        #1;
        chk("rstmid.val_async", 32'(dut_val), 32'd0);
        chk("rstmid.msg_async", 32'(dut_msg), 32'd0);
        fq.push_back(32'h11223344);
        upd();
        @(negedge clk);
        chk("rstmid.pop_in_reset", 32'(dut_pop), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        eb[0] = 8'h44; eb[1] = 8'h33; eb[2] = 8'h22; eb[3] = 8'h11;
        tick();
        chk("rstmid.repop", 32'(s_pop), 32'd1);
        chk("rstmid.val0", 32'(s_val), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rstmid.val", 32'(s_val), 32'd1);
            chk("rstmid.msg", 32'(s_msg), 32'(eb[i]));
            chk("rstmid.last", 32'(s_last), 32'(i == 3));
            chk("rstmid.nopop", 32'(s_pop), 32'd0);
        end
        tick();
        chk("rstmid.end_val", 32'(s_val), 32'd0);

        // Randomized traffic per configuration
        for (int c = 0; c < 3; c++) begin
            rst = 1'b0;
            sel = 2'(c);
            tb_rdy = 1'b0;
            fq.delete();
            exp_q.delete();
            upd();
            prev_stall = 1'b0;
            mask = (e_bits[c] >= 32) ? 32'hffff_ffff : ((32'd1 << e_bits[c]) - 32'd1);
            @(posedge clk);
            #1;
            rst = 1'b1;
            for (int t = 0; t < 200; t++) begin
                if ($urandom_range(0, 1) == 0 && fq.size() < 6) begin
                    fq.push_back($urandom() & mask);
                    upd();
                end
                tb_rdy = ($urandom_range(0, 3) != 0);
                tick();
                model(c);
            end
            tb_rdy = 1'b1;
            cnt = 0;
            while ((exp_q.size() != 0 || fq.size() != 0) && cnt < 100) begin
                tick();
                model(c);
                cnt++;
            end
            chk($sformatf("rand%0d.drained", c), 32'(exp_q.size() + fq.size()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
